wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 80 ++++++++
 tb/tb_wb_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MiniMIPS32 write-back sink: 32x32 GPR file plus HI/LO, with same-cycle
// write-through bypass to the two decode read ports and the execute HI/LO reader.
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              cpu_clk_75M,
    input  logic              cpu_rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    always_ff @(posedge cpu_clk_75M) begin
        if (cpu_rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            // regs[0] is never written, so it stays hard-wired to zero
            if (we && (waddr != '0)) begin
                regs[waddr] <= wdata;
            end
            if (whilo) begin
                hi_r <= hi_i;
                lo_r <= lo_i;
            end
        end
    end

    function automatic logic [DATA_W-1:0] gpr_read(
        input logic              re,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored
    );
        if (cpu_rst || !re || (ra == '0)) begin
            return '0;
        end else if (we && (ra == waddr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        rdata1 = gpr_read(re1, raddr1, regs[raddr1]);
        rdata2 = gpr_read(re2, raddr2, regs[raddr2]);
    end

    always_comb begin
        hi_o = hi_r;
        lo_o = lo_r;
        if (cpu_rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed per-cycle vector table, then a long random
// run against a behavioural model of the register file.
module tb_wb_regfile;

    logic        cpu_clk_75M = 1'b0;
    logic        cpu_rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    always #5 cpu_clk_75M = ~cpu_clk_75M;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .cpu_clk_75M (cpu_clk_75M),
        .cpu_rst     (cpu_rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .whilo       (whilo),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
        input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
        input logic hl, input logic [31:0] h, input logic [31:0] l,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic [31:0] ehi, input logic [31:0] elo
    );
        vec_t v;
        v.rst = rst; v.we = w; v.waddr = wa; v.wdata = wd;
        v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2;
        v.whilo = hl; v.hi = h; v.lo = l;
        v.e1 = e1; v.e2 = e2; v.ehi = ehi; v.elo = elo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(
        input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
        input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
        input logic hl, input logic [31:0] h, input logic [31:0] l
    );
        cpu_rst = rst; we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        whilo = hl; hi_i = h; lo_i = l;
    endtask

    // Behavioural reference for the random run
    logic [31:0] mregs [32];
    logic [31:0] mhi, mlo;

    function automatic logic [31:0] m_read(input logic r, input logic [4:0] a);
        if (cpu_rst || !r || a == 5'd0) return 32'h0;
        if (we && a == waddr) return wdata;
        return mregs[a];
    endfunction

    initial begin
        // rst we wa wd re1 a1 re2 a2 whilo hi lo | e1 e2 ehi elo
        vecs.push_back(mk(1,1,5,32'hDEAD_BEEF,1,5,1,5,1,32'hFFFF,32'hEEEE, 0,0,0,0));
        vecs.push_back(mk(1,1,5,32'hDEAD_BEEF,1,5,1,5,1,32'hFFFF,32'hEEEE, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,5,1,5,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,3,32'h1234_5678,1,3,0,3,0,0,0, 32'h1234_5678,0,0,0));
        vecs.push_back(mk(0,0,3,0,1,3,0,0,0,0,0, 32'h1234_5678,0,0,0));
        vecs.push_back(mk(0,1,0,32'hFFFF_FFFF,1,0,1,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0,1,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,7,32'hA,1,7,0,0,0,0,0, 32'hA,0,0,0));
        vecs.push_back(mk(0,1,7,32'hB,1,7,0,7,0,0,0, 32'hB,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,7,1,7,0,0,0, 32'hB,32'hB,0,0));
        vecs.push_back(mk(0,0,0,0,0,7,1,7,0,0,0, 0,32'hB,0,0));
        vecs.push_back(mk(0,1,9,32'hC0FFEE,1,9,1,9,0,0,0, 32'hC0FFEE,32'hC0FFEE,0,0));
        vecs.push_back(mk(0,1,20,32'h5,1,9,1,3,0,0,0, 32'hC0FFEE,32'h1234_5678,0,0));
        vecs.push_back(mk(0,0,0,0,1,20,1,7,1,32'h1,32'h2, 32'h5,32'hB,32'h1,32'h2));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,32'h9,32'h8, 0,0,32'h1,32'h2));
        vecs.push_back(mk(1,1,3,32'h7777,1,3,1,20,1,32'h5,32'h6, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,3,1,20,0,32'h5,32'h6, 0,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2,
                  vecs[i].whilo, vecs[i].hi, vecs[i].lo);
            #1;
            chk($sformatf("vec%0d rdata1", i), rdata1, vecs[i].e1);
            chk($sformatf("vec%0d rdata2", i), rdata2, vecs[i].e2);
            chk($sformatf("vec%0d hi_o", i), hi_o, vecs[i].ehi);
            chk($sformatf("vec%0d lo_o", i), lo_o, vecs[i].elo);
            @(posedge cpu_clk_75M);
            #1;
        end

        // Random run; the first cycle is a reset so model and DUT start aligned
        for (int c = 0; c < 10000; c++) begin
            drive((c == 0) || ($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), $urandom, $urandom);
            #1;
            chk("rnd rdata1", rdata1, m_read(re1, raddr1));
            chk("rnd rdata2", rdata2, m_read(re2, raddr2));
            chk("rnd hi_o", hi_o, cpu_rst ? 32'h0 : (whilo ? hi_i : mhi));
            chk("rnd lo_o", lo_o, cpu_rst ? 32'h0 : (whilo ? lo_i : mlo));
            @(posedge cpu_clk_75M);
            if (cpu_rst) begin
                for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
                mhi = 32'h0;
                mlo = 32'h0;
            end else begin
                if (we && waddr != 5'd0) mregs[waddr] = wdata;
                if (whilo) begin
                    mhi = hi_i;
                    mlo = lo_i;
                end
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
